bus_device_endpoint: RTL and testbench

Synthesizable per-device endpoint for the `bs_gnrtr_n_rbtr` bus: the device-side end of the `pndng`/`pop`/`D_pop` and `push`/`D_push` handshake that the bus-generator/arbiter drives. It holds a transmit FIFO, which the bus drains through `pop`, and a receive FIFO, which the bus fills through `push`. Both FIFOs are exposed to local logic through valid/ready ports. One instance sits on each `[bit][drvr]` slot of the bus, replacing the behavioural FIFO model used in simulation.

---
 rtl/bus_device_endpoint.sv | 115 +++++++++++
 tb/tb_bus_device_endpoint.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_device_endpoint.sv
// rtl/bus_device_endpoint.sv - device-side TX/RX FIFO endpoint for the bs_gnrtr_n_rbtr bus
module bus_device_endpoint #(
   parameter int         pckg_sz   = 16,
   parameter int         depth     = 8,
   parameter logic [7:0] id        = 8'd0,
   parameter logic [7:0] broadcast = 8'hFF
) (
   input  logic               clk,
   input  logic               reset,
   output logic               pndng,
   output logic [pckg_sz-1:0] D_pop,
   input  logic               pop,
   input  logic               push,
   input  logic [pckg_sz-1:0] D_push,
   input  logic               tx_valid,
   input  logic [pckg_sz-1:0] tx_data,
   output logic               tx_ready,
   output logic               rx_valid,
   output logic [pckg_sz-1:0] rx_data,
   input  logic               rx_ready,
   input  logic               clr_err,
   output logic               rx_overflow,
   output logic               misroute,
   output logic [7:0]         drop_cnt
);
   localparam int            AW   = $clog2(depth);
   localparam int            CW   = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(depth);

   logic [pckg_sz-1:0] tx_mem_q [depth];
   logic [pckg_sz-1:0] rx_mem_q [depth];

   logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
   logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
   logic [CW-1:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
   logic          rx_overflow_q, rx_overflow_d, misroute_q, misroute_d;
   logic [7:0]    drop_cnt_q, drop_cnt_d;

   logic          tx_wr, tx_rd, rx_wr, rx_rd;
   logic          dest_ok, ovf_evt, mis_evt, drop_evt;
   logic [7:0]    dest;

   // Status outputs come only from registered counts; data outputs are gated to hide stale storage
   assign pndng       = (tx_count_q != '0);
   assign tx_ready    = (tx_count_q != FULL);
   assign rx_valid    = (rx_count_q != '0);
   assign D_pop       = pndng    ? tx_mem_q[tx_rptr_q] : '0;
   assign rx_data     = rx_valid ? rx_mem_q[rx_rptr_q] : '0;
   assign rx_overflow = rx_overflow_q;
   assign misroute    = misroute_q;
   assign drop_cnt    = drop_cnt_q;

   // Next-state: FIFO pointers/counts, routing decision and sticky error bookkeeping
   always_comb begin
      dest    = D_push[pckg_sz-1 -: 8];
      dest_ok = (dest == id) || (dest == broadcast);
      tx_wr   = tx_valid && tx_ready;
      tx_rd   = pop && pndng;
      rx_rd   = rx_valid && rx_ready;
      // a local read in the same cycle frees a slot even when RX is full
      rx_wr   = push && dest_ok && ((rx_count_q != FULL) || rx_rd);
      ovf_evt = push && dest_ok && (rx_count_q == FULL) && !rx_rd;
      mis_evt = push && !dest_ok;
      drop_evt = ovf_evt || mis_evt;

      tx_wptr_d  = tx_wr ? tx_wptr_q + AW'(1) : tx_wptr_q;
      tx_rptr_d  = tx_rd ? tx_rptr_q + AW'(1) : tx_rptr_q;
      tx_count_d = tx_count_q + CW'(tx_wr) - CW'(tx_rd);
      rx_wptr_d  = rx_wr ? rx_wptr_q + AW'(1) : rx_wptr_q;
      rx_rptr_d  = rx_rd ? rx_rptr_q + AW'(1) : rx_rptr_q;
      rx_count_d = rx_count_q + CW'(rx_wr) - CW'(rx_rd);

      // clear and a fresh drop in the same cycle: the fresh event survives
      if (clr_err) begin
         rx_overflow_d = ovf_evt;
         misroute_d    = mis_evt;
         drop_cnt_d    = drop_evt ? 8'd1 : 8'd0;
      end else begin
         rx_overflow_d = rx_overflow_q || ovf_evt;
         misroute_d    = misroute_q || mis_evt;
         drop_cnt_d    = (drop_evt && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
      end
   end

   // Control state with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_wptr_q     <= '0;
         tx_rptr_q     <= '0;
         tx_count_q    <= '0;
         rx_wptr_q     <= '0;
         rx_rptr_q     <= '0;
         rx_count_q    <= '0;
         rx_overflow_q <= 1'b0;
         misroute_q    <= 1'b0;
         drop_cnt_q    <= '0;
      end else begin
         tx_wptr_q     <= tx_wptr_d;
         tx_rptr_q     <= tx_rptr_d;
         tx_count_q    <= tx_count_d;
         rx_wptr_q     <= rx_wptr_d;
         rx_rptr_q     <= rx_rptr_d;
         rx_count_q    <= rx_count_d;
         rx_overflow_q <= rx_overflow_d;
         misroute_q    <= misroute_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   // FIFO storage is not reset; writes are qualified by the handshakes above
   always_ff @(posedge clk) begin
      if (tx_wr) tx_mem_q[tx_wptr_q] <= tx_data;
      if (rx_wr) rx_mem_q[rx_wptr_q] <= D_push;
   end
endmodule

// File: tb/tb_bus_device_endpoint.sv
// tb/tb_bus_device_endpoint.sv - self-checking bench for bus_device_endpoint
module tb_bus_device_endpoint;
   localparam int         PW    = 16;
   localparam int         DEPTH = 8;
   localparam logic [7:0] MY_ID = 8'd2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          pndng, pop = 1'b0, push = 1'b0;
   logic [PW-1:0] D_pop, D_push = '0;
   logic          tx_valid = 1'b0, tx_ready;
   logic [PW-1:0] tx_data = '0;
   logic          rx_valid, rx_ready = 1'b0;
   logic [PW-1:0] rx_data;
   logic          clr_err = 1'b0, rx_overflow, misroute;
   logic [7:0]    drop_cnt;

   int checks = 0;
   int errors = 0;

   bus_device_endpoint #(.pckg_sz(PW), .depth(DEPTH), .id(MY_ID), .broadcast(8'hFF)) dut (
      .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop),
      .push(push), .D_push(D_push), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .clr_err(clr_err), .rx_overflow(rx_overflow), .misroute(misroute), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: two plain queues plus error flags
   logic [PW-1:0] m_tx[$];
   logic [PW-1:0] m_rx[$];
   logic          m_ovf = 1'b0, m_mis = 1'b0;
   int            m_cnt = 0;
   int            tx_n, rx_n;
   logic          rd_now, ovf_now, mis_now, hit;

   task automatic model_reset();
      m_tx.delete();
      m_rx.delete();
      m_ovf = 1'b0;
      m_mis = 1'b0;
      m_cnt = 0;
   endtask

   always @(negedge reset) model_reset();

   always @(posedge clk) begin
      if (!reset) begin
         model_reset();
      end else begin
         tx_n = m_tx.size();
         rx_n = m_rx.size();
         if (pop && tx_n > 0) void'(m_tx.pop_front());
         if (tx_valid && tx_n < DEPTH) m_tx.push_back(tx_data);
         hit     = (D_push[15:8] == MY_ID) || (D_push[15:8] == 8'hFF);
         rd_now  = rx_ready && rx_n > 0;
         mis_now = push && !hit;
         ovf_now = push && hit && rx_n == DEPTH && !rd_now;
         if (rd_now) void'(m_rx.pop_front());
         if (push && hit && !ovf_now) m_rx.push_back(D_push);
         if (clr_err) begin
            m_ovf = ovf_now;
            m_mis = mis_now;
            m_cnt = (ovf_now || mis_now) ? 1 : 0;
         end else begin
            if (ovf_now) m_ovf = 1'b1;
            if (mis_now) m_mis = 1'b1;
            if ((ovf_now || mis_now) && m_cnt < 255) m_cnt++;
         end
      end
      #1;
      check("pndng", pndng, m_tx.size() != 0);
      check("D_pop", D_pop, m_tx.size() != 0 ? m_tx[0] : '0);
      check("tx_ready", tx_ready, m_tx.size() < DEPTH);
      check("rx_valid", rx_valid, m_rx.size() != 0);
      check("rx_data", rx_data, m_rx.size() != 0 ? m_rx[0] : '0);
      check("rx_overflow", rx_overflow, m_ovf);
      check("misroute", misroute, m_mis);
      check("drop_cnt", drop_cnt, m_cnt);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   logic [PW-1:0] exp3 [3] = '{16'h0201, 16'h0302, 16'h0403};
   int            n;
   logic [PW-1:0] last;

   initial begin
      repeat (2) @(negedge clk);
      check("rst_pndng", pndng, 0);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      reset = 1'b1;
      @(negedge clk);
      check("rel_pndng", pndng, 0);
      check("rel_D_pop", D_pop, 0);
      check("rel_tx_ready", tx_ready, 1);
      check("rel_rx_data", rx_data, 0);
      check("rel_flags", {rx_overflow, misroute}, 0);

      // asynchronous reset with three packets queued
      tx_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tx_data = 16'h0A00 + 16'(i);
         @(negedge clk);
      end
      tx_valid = 1'b0;
      check("pre_rst_pndng", pndng, 1);
      #2 reset = 1'b0;
      #1;
      check("async_rst_pndng", pndng, 0);
      check("async_rst_D_pop", D_pop, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // TX ordering
      tx_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tx_data = exp3[i];
         @(negedge clk);
      end
      tx_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("order_pndng", pndng, 1);
         check("order_D_pop", D_pop, exp3[i]);
         pop = 1'b1;
         @(negedge clk);
         pop = 1'b0;
      end
      check("order_empty", pndng, 0);
      pop = 1'b1;
      @(negedge clk);
      pop = 1'b0;
      check("pop_empty_pndng", pndng, 0);
      check("pop_empty_ready", tx_ready, 1);

      // TX fill, then write+pop while full
      tx_valid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         tx_data = 16'h1000 + 16'(i);
         @(negedge clk);
      end
      check("full_tx_ready", tx_ready, 0);
      tx_data = 16'h1FFF;
      pop = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      check("full_pop_ready", tx_ready, 1);
      check("full_pop_head", D_pop, 16'h1001);
      n = 0;
      while (pndng && n < 20) begin
         @(negedge clk);
         n++;
      end
      pop = 1'b0;
      check("tx_count_after_full_pop", n, 7);

      // RX routing
      push = 1'b1;
      D_push = 16'h02AA; @(negedge clk);
      D_push = 16'hFF55; @(negedge clk);
      D_push = 16'h0312; @(negedge clk);
      push = 1'b0;
      check("route_misroute", misroute, 1);
      check("route_drop_cnt", drop_cnt, 1);
      check("route_first", rx_data, 16'h02AA);
      rx_ready = 1'b1;
      @(negedge clk);
      check("route_second", rx_data, 16'hFF55);
      @(negedge clk);
      rx_ready = 1'b0;
      check("route_empty", rx_valid, 0);

      // RX overflow
      push = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         D_push = 16'h0200 + 16'(i);
         @(negedge clk);
      end
      D_push = 16'h0277;
      @(negedge clk);
      check("ovf_flag", rx_overflow, 1);
      check("ovf_drop_cnt", drop_cnt, 2);
      D_push = 16'h0288;
      rx_ready = 1'b1;
      @(negedge clk);
      push = 1'b0;
      rx_ready = 1'b0;
      check("ovf_read_push_head", rx_data, 16'h0201);
      check("ovf_read_push_cnt", drop_cnt, 2);
      n = 0;
      last = '0;
      rx_ready = 1'b1;
      while (rx_valid && n < 20) begin
         last = rx_data;
         @(negedge clk);
         n++;
      end
      rx_ready = 1'b0;
      check("rx_count_full", n, 8);
      check("rx_last", last, 16'h0288);

      // saturation and clear
      push = 1'b1;
      D_push = 16'h0500;
      repeat (300) @(negedge clk);
      push = 1'b0;
      check("sat_drop_cnt", drop_cnt, 255);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      check("clr_errs", {rx_overflow, misroute, drop_cnt}, 0);
      push = 1'b1;
      D_push = 16'h0500;
      clr_err = 1'b1;
      @(negedge clk);
      push = 1'b0;
      clr_err = 1'b0;
      check("clr_drop_misroute", misroute, 1);
      check("clr_drop_cnt", drop_cnt, 1);
      check("clr_drop_ovf", rx_overflow, 0);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
